// File: rtl/tcm_mem_ram_dp.sv
// tcm_mem_ram_dp: dual-port TCM (port 0 fetch, port 1 load/store) with
// valid/ready handshakes, byte enables and a zeroing sweep after reset.
// Ports per p in {0,1}: req{p}_valid_i, req{p}_ready_o, addr{p}_i,
// data{p}_i, wr{p}_i (byte enables, 0 = read), resp{p}_valid_o, data{p}_o.
// Shared: clk_i, rst_i (sync, active-high), init_done_o, collision_o.
// Optional macro TCM_MEM_RAM_DP_BYPASS_EN: write-first forwarding on reads.
module tcm_mem_ram_dp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 14
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [ADDR_W-1:0]   addr0_i,
    input  logic [DATA_W-1:0]   data0_i,
    input  logic [DATA_W/8-1:0] wr0_i,
    output logic                resp0_valid_o,
    output logic [DATA_W-1:0]   data0_o,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [DATA_W-1:0]   data1_i,
    input  logic [DATA_W/8-1:0] wr1_i,
    output logic                resp1_valid_o,
    output logic [DATA_W-1:0]   data1_o,
    output logic                init_done_o,
    output logic                collision_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    // Sweep counter terminal value (DEPTH-1) in ADDR_W+1 bits.
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              run;
    logic              acc0, acc1;
    logic              coll_d;
    logic [DATA_W-1:0] rd0, rd1;
    logic              resp0_q, resp1_q, coll_q;
    logic [DATA_W-1:0] data0_q, data1_q;

    assign run          = (state_q == RUN);
    // Gating with rst_i keeps the handshake honest during a reset cycle.
    assign req0_ready_o = run && !rst_i;
    assign req1_ready_o = run && !rst_i;
    assign acc0         = req0_valid_i && req0_ready_o;
    assign acc1         = req1_valid_i && req1_ready_o;
    assign init_done_o  = run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Port 1 lanes are written first so a port 0 write to the same
    // lane of the same word overrides it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !run) mem_q[cnt_q[ADDR_W-1:0]] <= '0;
        for (int k = 0; k < NB; k++) begin
            if (acc1 && wr1_i[k])
                mem_q[addr1_i][k*8 +: 8] <= data1_i[k*8 +: 8];
            if (acc0 && wr0_i[k])
                mem_q[addr0_i][k*8 +: 8] <= data0_i[k*8 +: 8];
        end
    end

    always_comb begin
        rd0 = mem_q[addr0_i];
        rd1 = mem_q[addr1_i];
`ifdef TCM_MEM_RAM_DP_BYPASS_EN
        // Forward the post-write word: port 1 lanes, then port 0 lanes.
        for (int k = 0; k < NB; k++) begin
            if (acc1 && wr1_i[k] && addr1_i == addr0_i)
                rd0[k*8 +: 8] = data1_i[k*8 +: 8];
            if (acc0 && wr0_i[k])
                rd0[k*8 +: 8] = data0_i[k*8 +: 8];
            if (acc1 && wr1_i[k])
                rd1[k*8 +: 8] = data1_i[k*8 +: 8];
            if (acc0 && wr0_i[k] && addr0_i == addr1_i)
                rd1[k*8 +: 8] = data0_i[k*8 +: 8];
        end
`endif
    end

    assign coll_d = acc0 && acc1 && (addr0_i == addr1_i)
                    && |(wr0_i & wr1_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            resp0_q <= acc0;
            resp1_q <= acc1;
            if (acc0) data0_q <= rd0;
            if (acc1) data1_q <= rd1;
            coll_q  <= coll_d;
        end
    end

    assign resp0_valid_o = resp0_q;
    assign resp1_valid_o = resp1_q;
    assign data0_o       = data0_q;
    assign data1_o       = data1_q;
    assign collision_o   = coll_q;

endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// tb_tcm_mem_ram_dp: random and directed stimulus for tcm_mem_ram_dp
// checked against a word-array reference model.
module tb_tcm_mem_ram_dp;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic          req0_ready_o, req1_ready_o;
    logic [AW-1:0] addr0_i = '0, addr1_i = '0;
    logic [DW-1:0] data0_i = '0, data1_i = '0;
    logic [7:0]    wr0_i = '0, wr1_i = '0;
    logic          resp0_valid_o, resp1_valid_o;
    logic [DW-1:0] data0_o, data1_o;
    logic          init_done_o, collision_o;

    tcm_mem_ram_dp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .addr0_i(addr0_i), .data0_i(data0_i), .wr0_i(wr0_i),
        .resp0_valid_o(resp0_valid_o), .data0_o(data0_o),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .addr1_i(addr1_i), .data1_i(data1_i), .wr1_i(wr1_i),
        .resp1_valid_o(resp1_valid_o), .data1_o(data1_o),
        .init_done_o(init_done_o), .collision_o(collision_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] m_mem [N];
    bit            m_run = 0;
    int            m_cnt = 0;
    bit            e_rv0 = 0, e_rv1 = 0, e_col = 0;
    logic [DW-1:0] e_d0 = '0, e_d1 = '0;
    int            n_rv0 = 0, n_rv1 = 0;

    task automatic step(input bit r,
                        input bit v0, input int a0, input logic [DW-1:0] d0,
                        input logic [7:0] w0,
                        input bit v1, input int a1, input logic [DW-1:0] d1,
                        input logic [7:0] w1);
        logic [DW-1:0] nxt [N];
        bit acc0, acc1;
        rst_i = r;
        req0_valid_i = v0; addr0_i = AW'(a0); data0_i = d0; wr0_i = w0;
        req1_valid_i = v1; addr1_i = AW'(a1); data1_i = d1; wr1_i = w1;
        #1;
        check("ready0", {63'd0, req0_ready_o}, {63'd0, m_run && !r});
        check("ready1", {63'd0, req1_ready_o}, {63'd0, m_run && !r});
        acc0 = v0 && m_run && !r;
        acc1 = v1 && m_run && !r;
        if (r) begin
            m_run = 0; m_cnt = 0;
            e_rv0 = 0; e_rv1 = 0; e_col = 0; e_d0 = '0; e_d1 = '0;
        end else if (!m_run) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == N) m_run = 1;
            e_rv0 = 0; e_rv1 = 0; e_col = 0;
        end else begin
            nxt = m_mem;
            for (int k = 0; k < 8; k++) begin
                if (acc0 && w0[k])      nxt[a0][k*8 +: 8] = d0[k*8 +: 8];
                else if (acc1 && w1[k] && a1 == a0)
                                        nxt[a0][k*8 +: 8] = d1[k*8 +: 8];
                if (acc1 && w1[k] && !(acc0 && w0[k] && a0 == a1))
                                        nxt[a1][k*8 +: 8] = d1[k*8 +: 8];
            end
`ifdef TCM_MEM_RAM_DP_BYPASS_EN
            if (acc0) e_d0 = nxt[a0];
            if (acc1) e_d1 = nxt[a1];
`else
            if (acc0) e_d0 = m_mem[a0];
            if (acc1) e_d1 = m_mem[a1];
`endif
            e_rv0 = acc0; e_rv1 = acc1;
            e_col = acc0 && acc1 && a0 == a1 && (w0 & w1) != 0;
            m_mem = nxt;
        end
        @(posedge clk);
        #1;
        check("init_done", {63'd0, init_done_o}, {63'd0, m_run});
        check("resp0_valid", {63'd0, resp0_valid_o}, {63'd0, e_rv0});
        check("resp1_valid", {63'd0, resp1_valid_o}, {63'd0, e_rv1});
        check("data0", data0_o, e_d0);
        check("data1", data1_o, e_d1);
        check("collision", {63'd0, collision_o}, {63'd0, e_col});
        if (resp0_valid_o) n_rv0++;
        if (resp1_valid_o) n_rv1++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic sweep_reset;
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(N);
    endtask

    logic [DW-1:0] pat;

    initial begin
        for (int i = 0; i < N; i++) m_mem[i] = '0;

        // Reset sweep, then read everything back on both ports.
        sweep_reset;
        check("t1_init_done", {63'd0, init_done_o}, 64'd1);
        for (int i = 0; i < N; i++)
            step(0, 1, i, '0, '0, 1, N-1-i, '0, '0);
        idle(1);

        // Byte write then read.
        step(0, 0, 0, '0, '0, 1, 3, 64'h1122334455667788, 8'h0F);
        step(0, 1, 3, '0, '0, 0, 0, '0, '0);
        check("t2_data", data0_o, 64'h0000000055667788);

        // Same-cycle write on port 0 and read on port 1.
        step(0, 1, 5, 64'hAAAA, 8'hFF, 0, 0, '0, '0);
        step(0, 1, 5, 64'hBBBB, 8'hFF, 1, 5, '0, '0);
`ifdef TCM_MEM_RAM_DP_BYPASS_EN
        check("t3_data", data1_o, 64'hBBBB);
`else
        check("t3_data", data1_o, 64'hAAAA);
`endif

        // Write collision with port 0 priority.
        step(0, 1, 7, 64'h00000000000000FF, 8'h03,
                1, 7, 64'hFFFFFFFFFFFFEEEE, 8'hFF);
        check("t4_coll", {63'd0, collision_o}, 64'd1);
        step(0, 1, 7, '0, '0, 0, 0, '0, '0);
        check("t4_data", data0_o, 64'hFFFFFFFFFFFF00FF);
        check("t4_coll_off", {63'd0, collision_o}, 64'd0);

        // Disjoint enables on the same word are not a collision.
        step(0, 1, 9, 64'h11, 8'h01, 1, 9, 64'h2200, 8'h02);
        check("disjoint_coll", {63'd0, collision_o}, 64'd0);

        // Reset in sweep cycle 9, then in RUN after an accepted read.
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        idle(9);
        sweep_reset;
        check("t5_init_done", {63'd0, init_done_o}, 64'd1);
        step(0, 1, 2, '0, '0, 1, 4, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        check("t5_resp0_drop", {63'd0, resp0_valid_o}, 64'd0);
        idle(N);

        // Preload and full-throughput reads on both ports.
        for (int i = 0; i < N; i++) begin
            pat = 64'h0123456789ABCDEF ^ (64'h1111111111111111 * i);
            step(0, 1, i, pat, 8'hFF, 0, 0, '0, '0);
        end
        n_rv0 = 0; n_rv1 = 0;
        for (int i = 0; i < 32; i++)
            step(0, 1, i % N, '0, '0, 1, (i + 5) % N, '0, '0);
        idle(1);
        check("t6_count0", 64'(n_rv0), 64'd32);
        check("t6_count1", 64'(n_rv1), 64'd32);

        // Random traffic concentrated on a few words.
        for (int i = 0; i < 400; i++)
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 {$urandom, $urandom},
                 $urandom_range(0, 1) ? 8'h00 : 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3),
                 {$urandom, $urandom},
                 $urandom_range(0, 1) ? 8'h00 : 8'($urandom));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
